mo_lightpen_mouse: RTL and testbench

- Consumer end of the 25-bit `ps2_mouse` toggle-packet bus that the top level builds from user_io mouse strobes.
- Sits inside mo_core. Decodes each packet, applies the signed deltas to an absolute light-pen position clamped to the 320x200 MO screen, and tracks the mouse buttons.
- Compares the pen position against the video beam so the gate array can latch light-pen hit coordinates once per frame.

---
 rtl/mo_lightpen_mouse.sv | 135 +++++++++++++
 tb/tb_mo_lightpen_mouse.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mo_lightpen_mouse.sv
// mo_lightpen_mouse
// Turns the toggle-packet mouse bus into an absolute light-pen position on the
// 320x200 MO screen and tracks the left and right buttons. It also compares
// the pen position with the video beam so that the gate array can latch the
// hit coordinates once per frame.
//
// Ports
//   sysclk       system clock
//   reset        synchronous, active-high reset
//   ps2_mouse    [24] toggle, [23:16] Y diff, [15:8] X diff, [5] Y sign,
//                [4] X sign, [2:0] buttons M/R/L (L = bit 0)
//   beam_x/y     current active-area pixel X / line Y
//   beam_de      beam inside the active area
//   beam_vs      one-cycle frame-start pulse
//   pen_x/y      absolute pen position
//   pen_button   left button;  pen_button2  right button
//   pkt_stb      one-cycle pulse when a packet has been applied
//   pen_hit      beam currently under the pen (registered)
//   hit_x/y      beam position at the first hit of this frame
//   hit_valid    sticky: a hit has occurred this frame (cleared by beam_vs)
module mo_lightpen_mouse #(
  parameter int X_MAX   = 319,
  parameter int Y_MAX   = 199,
  parameter int HIT_WIN = 2
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic [24:0] ps2_mouse,
  input  logic [8:0]  beam_x,
  input  logic [7:0]  beam_y,
  input  logic        beam_de,
  input  logic        beam_vs,
  output logic [8:0]  pen_x,
  output logic [7:0]  pen_y,
  output logic        pen_button,
  output logic        pen_button2,
  output logic        pkt_stb,
  output logic        pen_hit,
  output logic [8:0]  hit_x,
  output logic [7:0]  hit_y,
  output logic        hit_valid
);

  localparam logic [8:0]         X_RST   = 9'((X_MAX + 1) / 2);
  localparam logic [7:0]         Y_RST   = 8'((Y_MAX + 1) / 2);
  localparam logic [8:0]         X_MAX_U = 9'(X_MAX);
  localparam logic [7:0]         Y_MAX_U = 8'(Y_MAX);
  localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);
  localparam logic signed [9:0]  WIN_S   = 10'(HIT_WIN);

  logic        tog_prev;
  logic        det;
  logic [8:0]  s0_dx, s0_dy;
  logic [1:0]  s0_btn;
  logic        s1_valid;
  logic [8:0]  s1_dx, s1_dy;
  logic [1:0]  s1_btn;

  logic signed [10:0] nx, ny;
  logic [8:0]         nx_c;
  logic [7:0]         ny_c;
  logic signed [9:0]  beam_dx;
  logic               hit_cond;

  // Overflow flags and the middle button carry nothing this block needs.
  logic unused_bits;
  assign unused_bits = ^{ps2_mouse[7:6], ps2_mouse[3:2]};

  always_comb begin
    nx   = $signed({2'b00, pen_x}) + $signed({{2{s1_dx[8]}}, s1_dx});
    // PS/2 Y is up-positive, screen Y is down-positive.
    ny   = $signed({3'b000, pen_y}) - $signed({{2{s1_dy[8]}}, s1_dy});
    nx_c = nx[8:0];
    ny_c = ny[7:0];
    if (nx[10])            nx_c = 9'd0;
    else if (nx > X_MAX_S) nx_c = X_MAX_U;
    if (ny[10])            ny_c = 8'd0;
    else if (ny > Y_MAX_S) ny_c = Y_MAX_U;
  end

  // 10-bit signed difference so the window never wraps at the screen edges.
  always_comb begin
    beam_dx  = $signed({1'b0, beam_x}) - $signed({1'b0, pen_x});
    hit_cond = beam_de && (beam_y == pen_y) && (beam_dx >= -WIN_S) && (beam_dx <= WIN_S);
  end

  always_ff @(posedge sysclk) begin
    // Reloaded during reset too, so a toggle level held across reset is not a packet.
    tog_prev <= ps2_mouse[24];
    if (reset) begin
      det         <= 1'b0;
      s1_valid    <= 1'b0;
      pkt_stb     <= 1'b0;
      pen_x       <= X_RST;
      pen_y       <= Y_RST;
      pen_button  <= 1'b0;
      pen_button2 <= 1'b0;
      pen_hit     <= 1'b0;
      hit_x       <= 9'd0;
      hit_y       <= 8'd0;
      hit_valid   <= 1'b0;
    end else begin
      // Edge k: detect the toggle change and capture the packet beside it.
      det    <= ps2_mouse[24] ^ tog_prev;
      s0_dx  <= {ps2_mouse[4], ps2_mouse[15:8]};
      s0_dy  <= {ps2_mouse[5], ps2_mouse[23:16]};
      s0_btn <= ps2_mouse[1:0];
      // Edge k+1: decoded deltas and buttons.
      s1_valid <= det;
      s1_dx    <= s0_dx;
      s1_dy    <= s0_dy;
      s1_btn   <= s0_btn;
      // Edge k+2: apply against the live pen register.
      pkt_stb <= s1_valid;
      if (s1_valid) begin
        pen_x       <= nx_c;
        pen_y       <= ny_c;
        pen_button  <= s1_btn[0];
        pen_button2 <= s1_btn[1];
      end

      pen_hit <= hit_cond;
      // Frame start wins over a coincident hit; that hit is dropped.
      if (beam_vs) begin
        hit_valid <= 1'b0;
      end else if (hit_cond && !hit_valid) begin
        hit_x     <= beam_x;
        hit_y     <= beam_y;
        hit_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mo_lightpen_mouse.sv
// Directed bench for mo_lightpen_mouse: reset state, packet latency, clamping,
// back-to-back packets, beam hit window, hit latch and frame-clear collision.
module tb_mo_lightpen_mouse;

  logic        sysclk = 1'b0;
  logic        reset;
  logic [24:0] ps2_mouse;
  logic [8:0]  beam_x;
  logic [7:0]  beam_y;
  logic        beam_de;
  logic        beam_vs;
  logic [8:0]  pen_x;
  logic [7:0]  pen_y;
  logic        pen_button;
  logic        pen_button2;
  logic        pkt_stb;
  logic        pen_hit;
  logic [8:0]  hit_x;
  logic [7:0]  hit_y;
  logic        hit_valid;

  int checks = 0;
  int errors = 0;
  logic tog = 1'b1;

  always #5 sysclk = ~sysclk;

  mo_lightpen_mouse dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .ps2_mouse   (ps2_mouse),
    .beam_x      (beam_x),
    .beam_y      (beam_y),
    .beam_de     (beam_de),
    .beam_vs     (beam_vs),
    .pen_x       (pen_x),
    .pen_y       (pen_y),
    .pen_button  (pen_button),
    .pen_button2 (pen_button2),
    .pkt_stb     (pkt_stb),
    .pen_hit     (pen_hit),
    .hit_x       (hit_x),
    .hit_y       (hit_y),
    .hit_valid   (hit_valid)
  );

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Flip the toggle with a new packet body (buttons: bit0 L, bit1 R, bit2 M).
  task automatic drive_pkt(input logic xs, input logic [7:0] xd,
                           input logic ys, input logic [7:0] yd, input logic [2:0] btn);
    tog = ~tog;
    ps2_mouse = {tog, yd, xd, 2'b00, ys, xs, 1'b0, btn};
  endtask

  // One packet through the pipe, checking the two-edge latency and the strobe width.
  task automatic send(input string tag, input logic xs, input logic [7:0] xd,
                      input logic ys, input logic [7:0] yd, input logic [2:0] btn,
                      input logic [8:0] ex, input logic [7:0] ey);
    logic [8:0] px0;
    px0 = pen_x;
    drive_pkt(xs, xd, ys, yd, btn);
    tick();
    chk({tag, "_stb_k"}, pkt_stb, 0);
    tick();
    chk({tag, "_stb_k1"}, pkt_stb, 0);
    chk({tag, "_x_hold"}, pen_x, px0);
    tick();
    chk({tag, "_stb_k2"}, pkt_stb, 1);
    chk({tag, "_x"}, pen_x, ex);
    chk({tag, "_y"}, pen_y, ey);
    tick();
    chk({tag, "_stb_end"}, pkt_stb, 0);
  endtask

  initial begin
    reset = 1'b1;
    ps2_mouse = 25'h1000000;
    beam_x = 9'd0; beam_y = 8'd0; beam_de = 1'b0; beam_vs = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_pen_x", pen_x, 160);
    chk("rst_pen_y", pen_y, 100);
    chk("rst_btn", {pen_button2, pen_button}, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_hit_xy", {hit_x, hit_y}, 0);
    chk("rst_pen_hit", pen_hit, 0);
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_stb", pkt_stb, 0);
      tick();
    end
    chk("rst_pen_x_hold", pen_x, 160);

    // +10 X, +5 Y (screen up), left button.
    send("p1", 1'b0, 8'h0A, 1'b0, 8'h05, 3'b001, 9'd170, 8'd95);
    chk("p1_btn_l", pen_button, 1);
    chk("p1_btn_r", pen_button2, 0);

    // Sweep line 95 with the pen at (170,95).
    beam_y = 8'd95; beam_de = 1'b1;
    for (int x = 0; x < 320; x++) begin
      beam_x = 9'(x);
      tick();
      chk("sweep_hit", pen_hit, (x >= 168 && x <= 172) ? 1 : 0);
    end
    chk("latch_x", hit_x, 168);
    chk("latch_y", hit_y, 95);
    chk("latch_valid", hit_valid, 1);

    // Frame start coincident with a hit: the clear wins.
    beam_x = 9'd170; beam_vs = 1'b1;
    tick();
    chk("vs_clear_valid", hit_valid, 0);
    chk("vs_pen_hit", pen_hit, 1);
    chk("vs_keep_x", hit_x, 168);
    beam_vs = 1'b0; beam_x = 9'd171;
    tick();
    chk("relatch_valid", hit_valid, 1);
    chk("relatch_x", hit_x, 171);
    beam_x = 9'd172;
    tick();
    chk("relatch_keep_x", hit_x, 171);
    beam_de = 1'b0;

    // Right + middle, no motion: middle ignored.
    send("p2", 1'b0, 8'h00, 1'b0, 8'h00, 3'b110, 9'd170, 8'd95);
    chk("p2_btn_l", pen_button, 0);
    chk("p2_btn_r", pen_button2, 1);

    // X = -256 clamps to 0.
    send("clamp_x0", 1'b1, 8'h00, 1'b0, 8'h00, 3'b000, 9'd0, 8'd95);

    // Window at the left edge: pen_x=0.
    beam_de = 1'b1; beam_y = 8'd95; beam_x = 9'd2;
    tick();
    chk("edge_hit_2", pen_hit, 1);
    beam_x = 9'd3;
    tick();
    chk("edge_hit_3", pen_hit, 0);
    beam_y = 8'd94; beam_x = 9'd0;
    tick();
    chk("edge_other_line", pen_hit, 0);
    beam_de = 1'b0;

    send("x255", 1'b0, 8'hFF, 1'b0, 8'h00, 3'b000, 9'd255, 8'd95);
    send("x300", 1'b0, 8'h2D, 1'b0, 8'h00, 3'b000, 9'd300, 8'd95);
    send("clamp_x319", 1'b0, 8'h64, 1'b0, 8'h00, 3'b000, 9'd319, 8'd95);
    send("clamp_y199", 1'b0, 8'h00, 1'b1, 8'h80, 3'b000, 9'd319, 8'd199);
    send("clamp_y0", 1'b0, 8'h00, 1'b0, 8'hFF, 3'b000, 9'd319, 8'd0);
    send("x_back160", 1'b1, 8'h61, 1'b0, 8'h00, 3'b000, 9'd160, 8'd0);

    // Two toggles on consecutive cycles, each +1 X.
    drive_pkt(1'b0, 8'h01, 1'b0, 8'h00, 3'b000);
    tick();
    drive_pkt(1'b0, 8'h01, 1'b0, 8'h00, 3'b000);
    tick();
    chk("b2b_stb_pre", pkt_stb, 0);
    tick();
    chk("b2b_stb1", pkt_stb, 1);
    chk("b2b_x161", pen_x, 161);
    tick();
    chk("b2b_stb2", pkt_stb, 1);
    chk("b2b_x162", pen_x, 162);
    tick();
    chk("b2b_stb_end", pkt_stb, 0);
    chk("b2b_x_hold", pen_x, 162);

    // Reset with a packet in flight: discarded.
    drive_pkt(1'b0, 8'h05, 1'b0, 8'h00, 3'b000);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_stb", pkt_stb, 0);
      tick();
    end
    chk("midrst_x", pen_x, 160);
    chk("midrst_y", pen_y, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
